// File: rtl/solitaire_dealer_if.sv
// Handshake and control bundle between the solitaire dealer and the game-state block.
interface solitaire_dealer_if #(
  parameter int CARD_W = 7
);
  logic              start;
  logic [15:0]       seed;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [CARD_W-1:0] out_card;
  logic [2:0]        out_dest;
  logic [4:0]        out_pos;
  logic              done;

  // The dealer drives the card stream and status.
  modport master (
    input  start, seed, out_ready,
    output busy, out_valid, out_card, out_dest, out_pos, done
  );

  // The consumer side starts a deal and accepts cards.
  modport slave (
    output start, seed, out_ready,
    input  busy, out_valid, out_card, out_dest, out_pos, done
  );
endinterface

// File: rtl/solitaire_dealer.sv
// Shuffles a 52-card deck with an LFSR-driven Fisher-Yates pass and streams
// the opening Klondike deal (28 tableau cards row-major, then 24 talon cards).
module solitaire_dealer #(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
  parameter int          CARD_W       = 7
) (
  input logic                clk,
  input logic                rst,
  solitaire_dealer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, SHUFFLE, DEAL_TAB, DEAL_TALON, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_step;
  logic [5:0]        deck [0:51];
  logic [5:0]        idx_i;
  logic [5:0]        idx_k;
  logic [2:0]        row, col;
  logic [5:0]        cand_j;
  logic              swap_ok;
  logic              xfer;
  logic [5:0]        k_nxt, sel_k;
  logic [2:0]        row_nxt, col_nxt, sel_row, sel_col;
  logic [CARD_W-1:0] pres_card;
  logic [2:0]        pres_dest;
  logic [4:0]        pres_pos;
  logic              valid_q;
  logic [CARD_W-1:0] card_q;
  logic [2:0]        dest_q;
  logic [4:0]        pos_q;

  // Shuffle candidate, LFSR advance and transfer detection.
  always_comb begin
    lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    cand_j    = lfsr[5:0];
    swap_ok   = (cand_j <= idx_i);
    xfer      = valid_q && bus.out_ready;
  end

  // Next deal position, and the card to present: the current position when
  // nothing is showing yet, otherwise the position after the one being accepted.
  always_comb begin
    k_nxt   = (idx_k == 6'd51) ? idx_k : idx_k + 6'd1;
    row_nxt = row;
    col_nxt = col + 3'd1;
    if (col == 3'd6) begin
      row_nxt = row + 3'd1;
      col_nxt = row + 3'd1;
    end
    sel_k   = valid_q ? k_nxt   : idx_k;
    sel_row = valid_q ? row_nxt : row;
    sel_col = valid_q ? col_nxt : col;
    if (sel_k < 6'd28) begin
      pres_card = {deck[sel_k], sel_row == sel_col};
      pres_dest = sel_col;
      pres_pos  = {2'b00, sel_row};
    end else begin
      pres_card = {deck[sel_k], 1'b0};
      pres_dest = 3'd7;
      pres_pos  = 5'(sel_k - 6'd28);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = INIT;
      INIT:       state_nxt = SHUFFLE;
      SHUFFLE:    if (swap_ok && idx_i == 6'd1) state_nxt = DEAL_TAB;
      DEAL_TAB:   if (xfer && idx_k == 6'd27) state_nxt = DEAL_TALON;
      DEAL_TALON: if (xfer && idx_k == 6'd51) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Deck storage: rebuilt in order during INIT, then swapped in place while shuffling.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int n = 0; n < 52; n++) deck[n] <= {4'(n % 13 + 1), 2'(n / 13)};
    end else if (state == SHUFFLE && swap_ok) begin
      deck[idx_i]  <= deck[cand_j];
      deck[cand_j] <= deck[idx_i];
    end
  end

  // LFSR, shuffle/deal counters and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= DEFAULT_SEED;
      idx_i   <= '0;
      idx_k   <= '0;
      row     <= '0;
      col     <= '0;
      valid_q <= 1'b0;
      card_q  <= '0;
      dest_q  <= '0;
      pos_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) lfsr <= (bus.seed == 16'd0) ? DEFAULT_SEED : bus.seed;
        end
        INIT: begin
          idx_i <= 6'd51;
          idx_k <= '0;
          row   <= '0;
          col   <= '0;
        end
        SHUFFLE: begin
          lfsr <= lfsr_step;
          if (swap_ok) idx_i <= idx_i - 6'd1;
        end
        DEAL_TAB, DEAL_TALON: begin
          if (!valid_q || bus.out_ready) begin
            if (valid_q && idx_k == 6'd51) begin
              valid_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              card_q  <= pres_card;
              dest_q  <= pres_dest;
              pos_q   <= pres_pos;
              if (valid_q) begin
                idx_k <= k_nxt;
                row   <= row_nxt;
                col   <= col_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == INIT) || (state == SHUFFLE) ||
                         (state == DEAL_TAB) || (state == DEAL_TALON);
  assign bus.done      = (state == DONE);
  assign bus.out_valid = valid_q;
  assign bus.out_card  = card_q;
  assign bus.out_dest  = dest_q;
  assign bus.out_pos   = pos_q;

endmodule

// File: tb/tb_solitaire_dealer.sv
// Self-checking bench for solitaire_dealer: a reference shuffle/deal model
// fills a scoreboard queue at each start, and a monitor pops it per transfer.
module tb_solitaire_dealer;

  typedef struct packed {
    logic [6:0] card;
    logic [2:0] dest;
    logic [4:0] pos;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   bp_mode = 1'b0;
  xfer_t sb[$];

  logic [6:0] rec_card [52];
  logic [2:0] rec_dest [52];
  logic [4:0] rec_pos  [52];
  logic [6:0] save_card [52];
  logic [2:0] save_dest [52];
  logic [4:0] save_pos  [52];
  int   rec_n = 0;

  solitaire_dealer_if dut_if ();

  solitaire_dealer dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: seeds the LFSR, runs Fisher-Yates, queues the 52 expected transfers.
  task automatic pushModel(input logic [15:0] s);
    logic [15:0] l;
    logic [5:0]  d [52];
    logic [5:0]  tmp;
    int          i, j, k;
    xfer_t       t;
    l = (s == 16'd0) ? 16'hACE1 : s;
    for (int n = 0; n < 52; n++) d[n] = {4'(n % 13 + 1), 2'(n / 13)};
    i = 51;
    while (i >= 1) begin
      j = int'(l[5:0]);
      if (j <= i) begin
        tmp = d[i]; d[i] = d[j]; d[j] = tmp;
        i--;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    k = 0;
    for (int r = 0; r < 7; r++) begin
      for (int c = r; c < 7; c++) begin
        t.card = {d[k], r == c};
        t.dest = 3'(c);
        t.pos  = 5'(r);
        sb.push_back(t);
        k++;
      end
    end
    for (int m = 28; m < 52; m++) begin
      t.card = {d[m], 1'b0};
      t.dest = 3'd7;
      t.pos  = 5'(m - 28);
      sb.push_back(t);
    end
  endtask

  // Consumer ready: always high, or a coin toss per cycle when backpressure is on.
  initial begin
    dut_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dut_if.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stalled outputs hold.
  initial begin
    xfer_t cur, held, e;
    bit    holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      cur = {dut_if.out_card, dut_if.out_dest, dut_if.out_pos};
      if (rst) begin
        holding = 1'b0;
      end else if (dut_if.out_valid && dut_if.out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("xfer_card", 32'(cur.card), 32'(e.card));
          checkOutput("xfer_dest", 32'(cur.dest), 32'(e.dest));
          checkOutput("xfer_pos",  32'(cur.pos),  32'(e.pos));
        end else begin
          checkOutput("xfer_extra", 32'(sb.size()), 32'd1);
        end
        if (rec_n < 52) begin
          rec_card[rec_n] = cur.card;
          rec_dest[rec_n] = cur.dest;
          rec_pos[rec_n]  = cur.pos;
        end
        rec_n++;
        holding = 1'b0;
      end else if (dut_if.out_valid) begin
        if (holding) checkOutput("hold_stable", 32'(cur), 32'(held));
        held    = cur;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
    end
  end

  // Queues the expected deal and pulses start for one cycle.
  task automatic applyStimulus(input logic [15:0] s);
    pushModel(s);
    rec_n = 0;
    @(posedge clk);
    #1;
    dut_if.start = 1'b1;
    dut_if.seed  = s;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    checkOutput("busy_after_start", 32'(dut_if.busy), 32'd1);
    checkOutput("done_after_start", 32'(dut_if.done), 32'd0);
  endtask

  // Bounded wait for DONE followed by end-of-deal status checks.
  task automatic waitDone();
    int cyc;
    cyc = 0;
    while (!dut_if.done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_reached", 32'(dut_if.done), 32'd1);
    checkOutput("busy_in_done", 32'(dut_if.busy), 32'd0);
    checkOutput("valid_in_done", 32'(dut_if.out_valid), 32'd0);
    checkOutput("xfer_count", 32'(rec_n), 32'd52);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic saveRun();
    for (int n = 0; n < 52; n++) begin
      save_card[n] = rec_card[n];
      save_dest[n] = rec_dest[n];
      save_pos[n]  = rec_pos[n];
    end
  endtask

  function automatic int diffRun();
    int d;
    d = 0;
    for (int n = 0; n < 52; n++)
      if (rec_card[n] !== save_card[n] || rec_dest[n] !== save_dest[n] || rec_pos[n] !== save_pos[n]) d++;
    return d;
  endfunction

  initial begin
    logic [51:0] seen;
    int          vis, cyc, idx;
    dut_if.start = 1'b0;
    dut_if.seed  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(dut_if.busy), 32'd0);
    checkOutput("reset_valid", 32'(dut_if.out_valid), 32'd0);
    checkOutput("reset_done", 32'(dut_if.done), 32'd0);
    rst = 1'b0;

    $display("[TB] full-throughput deal, seed 1234");
    applyStimulus(16'h1234);
    waitDone();
    seen = '0;
    vis  = 0;
    for (int n = 0; n < 52; n++) begin
      idx = int'(rec_card[n][2:1]) * 13 + int'(rec_card[n][6:3]) - 1;
      if (rec_card[n][6:3] >= 4'd1 && rec_card[n][6:3] <= 4'd13) seen[idx] = 1'b1;
      if (rec_card[n][0]) vis++;
    end
    checkOutput("perm_all_cards", 32'(seen), 32'hFFFF_FFFF);
    checkOutput("perm_all_cards_hi", 32'(seen[51:32]), 32'h000F_FFFF);
    checkOutput("visible_count", 32'(vis), 32'd7);
    checkOutput("map1",  {rec_dest[0],  rec_pos[0],  rec_card[0][0]},  {3'd0, 5'd0,  1'b1});
    checkOutput("map2",  {rec_dest[1],  rec_pos[1],  rec_card[1][0]},  {3'd1, 5'd0,  1'b0});
    checkOutput("map7",  {rec_dest[6],  rec_pos[6],  rec_card[6][0]},  {3'd6, 5'd0,  1'b0});
    checkOutput("map8",  {rec_dest[7],  rec_pos[7],  rec_card[7][0]},  {3'd1, 5'd1,  1'b1});
    checkOutput("map28", {rec_dest[27], rec_pos[27], rec_card[27][0]}, {3'd6, 5'd6,  1'b1});
    checkOutput("map29", {rec_dest[28], rec_pos[28], rec_card[28][0]}, {3'd7, 5'd0,  1'b0});
    checkOutput("map52", {rec_dest[51], rec_pos[51], rec_card[51][0]}, {3'd7, 5'd23, 1'b0});
    saveRun();

    $display("[TB] backpressure deal, seed 1234");
    bp_mode = 1'b1;
    applyStimulus(16'h1234);
    waitDone();
    bp_mode = 1'b0;
    checkOutput("bp_same_seq", 32'(diffRun()), 32'd0);

    $display("[TB] start ignored during shuffle");
    applyStimulus(16'h1234);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("shuffle_busy", 32'(dut_if.busy), 32'd1);
    checkOutput("shuffle_no_valid", 32'(dut_if.out_valid), 32'd0);
    dut_if.start = 1'b1;
    dut_if.seed  = 16'h5555;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    waitDone();
    checkOutput("ignored_start_seq", 32'(diffRun()), 32'd0);

    $display("[TB] zero seed vs default seed");
    applyStimulus(16'h0000);
    waitDone();
    saveRun();
    applyStimulus(16'hACE1);
    waitDone();
    checkOutput("seed0_eq_default", 32'(diffRun()), 32'd0);

    $display("[TB] seed 1 vs seed 2");
    applyStimulus(16'h0001);
    waitDone();
    saveRun();
    applyStimulus(16'h0002);
    waitDone();
    checkOutput("seeds_differ", 32'(diffRun() != 0), 32'd1);

    $display("[TB] reset during tableau deal");
    applyStimulus(16'h1234);
    cyc = 0;
    while (rec_n < 10 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reached_deal", 32'(rec_n >= 10), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(dut_if.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(dut_if.busy), 32'd0);
    checkOutput("rst_done", 32'(dut_if.done), 32'd0);
    checkOutput("rst_outs", {dut_if.out_card, dut_if.out_dest, dut_if.out_pos}, 32'd0);
    sb.delete();
    cyc = rec_n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(dut_if.busy), 32'd0);
    checkOutput("idle_valid", 32'(dut_if.out_valid), 32'd0);
    checkOutput("idle_done", 32'(dut_if.done), 32'd0);
    checkOutput("idle_no_xfer", 32'(rec_n), 32'(cyc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
